// File: rtl/mul32_seq_ctrl.sv
// mul32_seq_ctrl: sequential control stage around a combinational 32x32
// unsigned multiplier. Operands are registered as magnitudes and held for
// SETTLE_CYCLES clocks. The product is then captured, re-signed and offered
// downstream over a valid/ready handshake. Holding the inputs turns the long
// ripple path through the multiplier into a registered multicycle path.
module mul32_seq_ctrl #(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic        in_signed,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic [63:0] mul_product,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_product,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DONE   = 2'd2
  } state_t;

  // The counter starts at SETTLE_CYCLES-1, so the capture happens exactly
  // SETTLE_CYCLES edges after the accept edge.
  localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

  generate
    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
      $error("mul32_seq_ctrl: SETTLE_CYCLES must be in 1..15");
    end
  endgenerate

  state_t      state_reg;
  state_t      state_next;
  logic [3:0]  cnt_reg;
  logic        neg_reg;
  logic [31:0] mul_a_reg;
  logic [31:0] mul_b_reg;
  logic [63:0] out_product_reg;
  logic        out_valid_reg;

  logic        accept;
  logic        capture;
  logic        retire;

  // Both operands go through the same magnitude conversion. The two's
  // complement negation is mod 2^32, so 0x80000000 maps to itself, which is
  // the correct unsigned magnitude 2^31.
  logic [31:0] op_in  [2];
  logic [31:0] op_mag [2];

  assign op_in[0] = in_a;
  assign op_in[1] = in_b;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_mag
      assign op_mag[gi] = (in_signed & op_in[gi][31]) ? (~op_in[gi] + 32'd1)
                                                       : op_in[gi];
    end
  endgenerate

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic and the per-state strobes that drive the datapath.
  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    capture    = 1'b0;
    retire     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          accept     = 1'b1;
          state_next = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_reg == 4'd0) begin
          capture    = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          retire     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: operand capture, settle countdown and result capture/hold.
  // The result is kept after the handshake; only out_valid drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_a_reg       <= 32'd0;
      mul_b_reg       <= 32'd0;
      neg_reg         <= 1'b0;
      cnt_reg         <= 4'd0;
      out_product_reg <= 64'd0;
      out_valid_reg   <= 1'b0;
    end else begin
      if (accept) begin
        mul_a_reg <= op_mag[0];
        mul_b_reg <= op_mag[1];
        neg_reg   <= in_signed & (in_a[31] ^ in_b[31]);
        cnt_reg   <= CNT_LOAD;
      end else if (state_reg == SETTLE && cnt_reg != 4'd0) begin
        cnt_reg <= cnt_reg - 4'd1;
      end

      if (capture) begin
        out_product_reg <= neg_reg ? (~mul_product + 64'd1) : mul_product;
        out_valid_reg   <= 1'b1;
      end else if (retire) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign in_ready    = (state_reg == IDLE);
  assign busy        = (state_reg != IDLE);
  assign mul_a       = mul_a_reg;
  assign mul_b       = mul_b_reg;
  assign out_valid   = out_valid_reg;
  assign out_product = out_product_reg;

endmodule

// File: tb/tb_mul32_seq_ctrl.sv
// tb_mul32_seq_ctrl: scoreboard bench for mul32_seq_ctrl. Three instances
// (SETTLE_CYCLES = 4, 1, 15) each run the same directed and random stimulus.
// Expected products come from signed/unsigned integer arithmetic and are
// queued at accept time; a monitor pops and compares on every handshake.
module tb_mul32_seq_ctrl;

  logic clk;
  int   checks     = 0;
  int   miscompares = 0;
  int   done_cnt   = 0;
  int   cyc        = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running cycle count used to measure accept spacing.
  always @(posedge clk) cyc++;

  // Reference product: plain integer multiply of the operands as numbers.
  function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b,
                                           input logic s);
    longint sa;
    longint sb;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    return {32'd0, a} * {32'd0, b};
  endfunction

  // Reference magnitude: absolute value of the operand as a number.
  function automatic logic [31:0] ref_mag(input logic [31:0] a, input logic s);
    longint v;
    v = s ? longint'($signed(a)) : longint'({32'd0, a});
    if (v < 0) v = -v;
    return v[31:0];
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'h8000_0000;
      3:       return 32'hFFFF_FFFF;
      4:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_cfg
      localparam int SC = (gi == 0) ? 4 : ((gi == 1) ? 1 : 15);

      logic        rst_n;
      logic        in_valid;
      logic        in_ready;
      logic [31:0] in_a;
      logic [31:0] in_b;
      logic        in_signed;
      logic [31:0] mul_a;
      logic [31:0] mul_b;
      logic [63:0] mul_product;
      logic        out_valid;
      logic        out_ready;
      logic [63:0] out_product;
      logic        busy;
      logic [63:0] exp_q [$];
      logic [63:0] mon_e;

      mul32_seq_ctrl #(.SETTLE_CYCLES(SC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_signed   (in_signed),
        .mul_a       (mul_a),
        .mul_b       (mul_b),
        .mul_product (mul_product),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_product (out_product),
        .busy        (busy)
      );

      // Behavioural unsigned multiplier.
      assign mul_product = {32'd0, mul_a} * {32'd0, mul_b};

      task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
          miscompares++;
          $display("FAIL S=%0d %s: got %h, want %h", SC, nm, got, want);
        end
      endtask

      task automatic wait_ready();
        int w;
        w = 0;
        while (!in_ready && w < 60) begin
          @(posedge clk); #1; w++;
        end
        chk("in_ready before accept", 64'(in_ready), 64'd1);
      endtask

      // One complete operation; d = cycles of backpressure after out_valid.
      task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                            input int d, output int acc_cyc);
        int          lat;
        logic        hold_ok;
        logic [63:0] e;
        logic [31:0] ma;
        logic [31:0] mb;
        wait_ready();
        e  = ref_prod(a, b, s);
        ma = ref_mag(a, s);
        mb = ref_mag(b, s);
        in_valid = 1'b1; in_a = a; in_b = b; in_signed = s;
        out_ready = (d == 0);
        exp_q.push_back(e);
        @(posedge clk); #1;
        acc_cyc = cyc;
        in_valid = 1'b0; in_a = $urandom; in_b = $urandom; in_signed = 1'($urandom);
        chk("mul_a", 64'(mul_a), 64'(ma));
        chk("mul_b", 64'(mul_b), 64'(mb));
        lat = 0;
        hold_ok = 1'b1;
        while (!out_valid && lat < 40) begin
          if (in_ready || !busy) hold_ok = 1'b0;
          @(posedge clk); #1; lat++;
        end
        chk("latency", 64'(lat), 64'(SC));
        repeat (d) begin
          @(posedge clk); #1;
          if (!out_valid || out_product !== e || in_ready || !busy) hold_ok = 1'b0;
        end
        out_ready = 1'b1;
        chk("busy/valid held", 64'(hold_ok), 64'd1);
        @(posedge clk); #1;
        chk("idle in_ready", 64'(in_ready), 64'd1);
        chk("idle busy", 64'(busy), 64'd0);
        chk("idle out_valid", 64'(out_valid), 64'd0);
        chk("product retained", out_product, e);
        chk("mul_a retained", 64'(mul_a), 64'(ma));
      endtask

      task automatic chk_reset_outputs(input string tag);
        chk({tag, " in_ready"}, 64'(in_ready), 64'd1);
        chk({tag, " out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, " out_product"}, out_product, 64'd0);
        chk({tag, " mul_a"}, 64'(mul_a), 64'd0);
        chk({tag, " mul_b"}, 64'(mul_b), 64'd0);
        chk({tag, " busy"}, 64'(busy), 64'd0);
      endtask

      // Monitor: a handshake occurs at the next rising edge when both are high.
      always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected out_valid", 64'(out_valid), 64'd0);
          end else begin
            mon_e = exp_q.pop_front();
            chk("out_product", out_product, mon_e);
            $display("S=%0d result %h expected %h", SC, out_product, mon_e);
          end
        end
      end

      initial begin : stim
        int          acc0;
        int          acc1;
        int          acc2;
        logic [63:0] p;
        logic [31:0] ma;
        logic [31:0] mb;
        logic        ok;
        int          w;

        rst_n = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_signed = 1'b0;
        out_ready = 1'b0;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed corner cases.
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, acc0);
        run_op(32'hFFFF_FFFD, 32'h0000_0007, 1'b1, 1, acc0);
        run_op(32'hFFFF_FFFD, 32'hFFFF_FFF9, 1'b1, 0, acc0);
        run_op(32'h8000_0000, 32'h8000_0000, 1'b1, 2, acc0);
        run_op(32'h0000_0000, 32'hFFFF_FFFB, 1'b1, 0, acc0);

        // Backpressure with a competing request held on the input.
        wait_ready();
        in_valid = 1'b1; in_a = 32'h0001_0003; in_b = 32'h0000_0011; in_signed = 1'b0;
        out_ready = 1'b0;
        exp_q.push_back(ref_prod(32'h0001_0003, 32'h0000_0011, 1'b0));
        @(posedge clk); #1;
        in_valid = 1'b0;
        w = 0;
        while (!out_valid && w < 40) begin
          @(posedge clk); #1; w++;
        end
        chk("bp out_valid", 64'(out_valid), 64'd1);
        p = out_product; ma = mul_a; mb = mul_b;
        in_valid = 1'b1; in_a = 32'hFFFF_FFFE; in_b = 32'h0000_0009; in_signed = 1'b1;
        ok = 1'b1;
        repeat (10) begin
          @(posedge clk); #1;
          if (!out_valid || out_product !== p || mul_a !== ma || mul_b !== mb || in_ready)
            ok = 1'b0;
        end
        chk("bp stable", 64'(ok), 64'd1);
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp idle in_ready", 64'(in_ready), 64'd1);
        chk("bp idle out_valid", 64'(out_valid), 64'd0);
        exp_q.push_back(ref_prod(32'hFFFF_FFFE, 32'h0000_0009, 1'b1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp new mul_a", 64'(mul_a), 64'(ref_mag(32'hFFFF_FFFE, 1'b1)));
        chk("bp new accepted", 64'(in_ready), 64'd0);
        w = 0;
        while (!in_ready && w < 40) begin
          @(posedge clk); #1; w++;
        end

        // Reset in the middle of an operation.
        wait_ready();
        in_valid = 1'b1; in_a = 32'h0000_1234; in_b = 32'h0000_5678; in_signed = 1'b0;
        out_ready = 1'b0;
        exp_q.push_back(ref_prod(32'h0000_1234, 32'h0000_5678, 1'b0));
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        if (exp_q.size() > 0) void'(exp_q.pop_back());
        #1;
        chk_reset_outputs("midop reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        ok = 1'b1;
        repeat (SC + 3) begin
          @(posedge clk); #1;
          if (out_valid) ok = 1'b0;
        end
        chk("no valid after reset", 64'(ok), 64'd1);
        run_op(32'd5, 32'd6, 1'b0, 0, acc0);

        // Back-to-back with out_ready held high.
        run_op(pick(), pick(), 1'b1, 0, acc0);
        run_op(pick(), pick(), 1'b0, 0, acc1);
        run_op(pick(), pick(), 1'b1, 0, acc2);
        chk("spacing 1", 64'(acc1 - acc0), 64'(SC + 2));
        chk("spacing 2", 64'(acc2 - acc1), 64'(SC + 2));

        // Randomized operations.
        repeat (30) begin
          run_op(pick(), pick(), 1'($urandom_range(0, 1)), $urandom_range(0, 3), acc0);
        end

        @(posedge clk); #1;
        chk("queue drained", 64'(exp_q.size()), 64'd0);
        done_cnt++;
      end
    end
  endgenerate

  initial begin : finisher
    int c;
    c = 0;
    while (done_cnt < 3 && c < 20000) begin
      @(posedge clk); c++;
    end
    if (done_cnt < 3) begin
      checks++;
      miscompares++;
      $display("FAIL timeout: got %0d finished instances, want 3", done_cnt);
    end
    $display("== %0d vectors applied, %0d miscompares ==", checks, miscompares);
    $finish;
  end

endmodule
